// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared types and constants for the register-file write-port scheduler.
//   DATA_W / ADDR_W : default register data and address widths
//   reg_addr_t      : register address
//   reg_data_t      : register data word
//   fifo_entry_t    : one buffered MDU result {addr, data}
//   REG_ZERO        : the hard-wired zero register, never written
// ---------------------------------------------------------------------------
package regfile_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;

   typedef struct packed {
      reg_addr_t addr;
      reg_data_t data;
   } fifo_entry_t;

   localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_wr_fifo.sv
// ---------------------------------------------------------------------------
// regfile_wr_fifo
// Small synchronous FIFO buffering MDU results until the register-file write
// port is free. DEPTH must be a power of two so the pointers wrap naturally.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data : write one entry (caller guarantees not full)
//   pop             : discard the head entry (caller guarantees not empty)
//   head_data       : current head entry
//   count           : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module regfile_wr_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage needs no reset: an entry is only ever read after it was pushed,
   // and count alone decides whether anything valid is stored.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers and occupancy. A simultaneous push and pop leaves count alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_data = mem[rd_ptr];

endmodule

// File: rtl/regfile_write_sched.sv
// ---------------------------------------------------------------------------
// regfile_write_sched
// Shares the single register-file write port between the writeback stage and
// the multi-cycle multiply/divide unit. MDU results wait in a small FIFO, a
// busy scoreboard tracks registers still awaiting an MDU result, and decode
// is stalled on hazards.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : the write sitting on the port this cycle is forwarded to the
//               decode read data, so no stall is needed for it
//   undefined : read data passes straight through and decode stalls while a
//               matching write is on the port
//
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   wb_valid/wb_addr/wb_data      : writeback stage write request
//   mdu_valid/mdu_ready/mdu_addr/mdu_data : MDU result handshake
//   issue_valid/issue_addr/issue_ready    : MDU issue, marks dest busy
//   rs_addr, rt_addr              : decode read addresses
//   rf_rdata_a, rf_rdata_b        : raw register file read data
//   rdata_a, rdata_b              : read data delivered to decode
//   stall                         : decode must hold
//   pipe_hold                     : writeback must not write this cycle
//   rf_we/rf_waddr/rf_wdata       : registered register file write port
// ---------------------------------------------------------------------------
module regfile_write_sched #(
   parameter int DATA_W     = regfile_pkg::DATA_W,
   parameter int ADDR_W     = regfile_pkg::ADDR_W,
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              mdu_valid,
   output logic              mdu_ready,
   input  logic [ADDR_W-1:0] mdu_addr,
   input  logic [DATA_W-1:0] mdu_data,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_addr,
   output logic              issue_ready,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic [DATA_W-1:0] rf_rdata_a,
   input  logic [DATA_W-1:0] rf_rdata_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   output logic              stall,
   output logic              pipe_hold,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
);

   import regfile_pkg::*;

   localparam int NREG    = 1 << ADDR_W;
   localparam int ENTRY_W = ADDR_W + DATA_W;
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int SC_W    = $clog2(STARVE_MAX + 1);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [CNT_W-1:0]   fifo_count;
   logic [ENTRY_W-1:0] fifo_head;
   logic [ADDR_W-1:0]  head_addr;
   logic [DATA_W-1:0]  head_data;
   logic               fifo_empty;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_wr;
   logic               wb_win;
   logic [SC_W-1:0]    starve_cnt;
   logic [SC_W-1:0]    starve_next;
   logic [NREG-1:0]    busy;
   logic [NREG-1:0]    busy_set;
   logic [NREG-1:0]    busy_clr;
   logic [NREG-1:0]    busy_next;
   logic               pend_hit;

   regfile_wr_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data ({mdu_addr, mdu_data}),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .count     (fifo_count)
   );

   assign head_addr  = fifo_head[ENTRY_W-1 -: ADDR_W];
   assign head_data  = fifo_head[DATA_W-1:0];
   assign fifo_empty = (fifo_count == '0);

   // Writeback owns the port whenever it writes a real register; the FIFO
   // head drains in any other cycle. During pipe_hold writeback is ignored
   // even if it misbehaves, so the starving entry is guaranteed to go out.
   // A full FIFO refuses a push even when it pops in the same cycle.
   assign wb_win    = wb_valid && (wb_addr != ZERO_ADDR) && !pipe_hold;
   assign fifo_pop  = !wb_win && !fifo_empty;
   assign fifo_wr   = fifo_pop && (head_addr != ZERO_ADDR);
   assign mdu_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
   assign fifo_push = mdu_valid && mdu_ready;

   // Registered write port: the winner of cycle N is presented in N+1.
   // Address/data only move on a real write, so they hold the last one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= wb_win || fifo_wr;
         if (wb_win) begin
            rf_waddr <= wb_addr;
            rf_wdata <= wb_data;
         end else if (fifo_wr) begin
            rf_waddr <= head_addr;
            rf_wdata <= head_data;
         end
      end
   end

   // Starvation counter: grows while writeback keeps beating a non-empty
   // FIFO and falls back to zero as soon as the FIFO drains or gets the port.
   always_comb begin
      starve_next = '0;
      if (!fifo_empty && wb_win) begin
         if (starve_cnt == SC_W'(STARVE_MAX)) begin
            starve_next = starve_cnt;
         end else begin
            starve_next = starve_cnt + SC_W'(1);
         end
      end
   end

   // pipe_hold follows the counter reaching its limit by one cycle. The hold
   // cycle itself pops the FIFO, which clears the counter, so the hold lasts
   // exactly one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
         pipe_hold  <= 1'b0;
      end else begin
         starve_cnt <= starve_next;
         pipe_hold  <= (starve_next == SC_W'(STARVE_MAX));
      end
   end

   // Scoreboard update. The clear fires on the cycle the head is popped, so
   // the register is no longer busy in the cycle its value is on the port.
   // Applying the set after the clear lets a fresh issue win a collision.
   // Writebacks never touch the scoreboard, even to a busy register.
   always_comb begin
      busy_set = '0;
      busy_clr = '0;
      if (issue_valid && issue_ready && (issue_addr != ZERO_ADDR)) begin
         busy_set[issue_addr] = 1'b1;
      end
      if (fifo_pop) begin
         busy_clr[head_addr] = 1'b1;
      end
      busy_next    = (busy & ~busy_clr) | busy_set;
      busy_next[0] = 1'b0;
   end

   // Scoreboard register; reset forgets all outstanding MDU results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   assign issue_ready = !busy[issue_addr];

`ifdef REGFILE_BYPASS_EN
   assign rdata_a  = (rf_we && (rf_waddr == rs_addr) && (rs_addr != ZERO_ADDR)) ? rf_wdata : rf_rdata_a;
   assign rdata_b  = (rf_we && (rf_waddr == rt_addr) && (rt_addr != ZERO_ADDR)) ? rf_wdata : rf_rdata_b;
   assign pend_hit = 1'b0;
`else
   assign rdata_a  = rf_rdata_a;
   assign rdata_b  = rf_rdata_b;
   assign pend_hit = rf_we && (rf_waddr != ZERO_ADDR) &&
                     ((rf_waddr == rs_addr) || (rf_waddr == rt_addr));
`endif

   assign stall = busy[rs_addr] | busy[rt_addr] | pipe_hold | pend_hit;

endmodule

// File: tb/tb_regfile_write_sched.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_sched
// Directed bench for regfile_write_sched. Inputs change 1ns after the rising
// edge; outputs are sampled on the falling edge. Expected values are worked
// out by hand from the cycle timelines noted above each task.
// ---------------------------------------------------------------------------
module tb_regfile_write_sched;

   logic        clk;
   logic        rst_n;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_addr;
   logic [31:0] mdu_data;
   logic        issue_valid;
   logic [4:0]  issue_addr;
   logic        issue_ready;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rf_rdata_a;
   logic [31:0] rf_rdata_b;
   logic [31:0] rdata_a;
   logic [31:0] rdata_b;
   logic        stall;
   logic        pipe_hold;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int total = 0;
   int bad   = 0;

   regfile_write_sched dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .mdu_valid   (mdu_valid),
      .mdu_ready   (mdu_ready),
      .mdu_addr    (mdu_addr),
      .mdu_data    (mdu_data),
      .issue_valid (issue_valid),
      .issue_addr  (issue_addr),
      .issue_ready (issue_ready),
      .rs_addr     (rs_addr),
      .rt_addr     (rt_addr),
      .rf_rdata_a  (rf_rdata_a),
      .rf_rdata_b  (rf_rdata_b),
      .rdata_a     (rdata_a),
      .rdata_b     (rdata_b),
      .stall       (stall),
      .pipe_hold   (pipe_hold),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Return all request inputs to idle.
   task automatic idle_inputs();
      wb_valid    = 1'b0;
      wb_addr     = '0;
      wb_data     = '0;
      mdu_valid   = 1'b0;
      mdu_addr    = '0;
      mdu_data    = '0;
      issue_valid = 1'b0;
      issue_addr  = '0;
      rs_addr     = '0;
      rt_addr     = '0;
   endtask

   // Advance to just after the next rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Reset with a writeback request pending: nothing may reach the port.
   task automatic test_reset();
      rst_n      = 1'b0;
      rf_rdata_a = 32'h1111_1111;
      rf_rdata_b = 32'h2222_2222;
      idle_inputs();
      wb_valid = 1'b1;
      wb_addr  = 5'd3;
      wb_data  = 32'd100;
      repeat (3) @(negedge clk);
      total++; if (rf_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_rf_we: got %0b want 0", rf_we); end
      total++; if (rf_waddr !== 5'd0) begin bad++; $display("[TB] FAIL reset_rf_waddr: got %0d want 0", rf_waddr); end
      total++; if (rf_wdata !== 32'd0) begin bad++; $display("[TB] FAIL reset_rf_wdata: got %0h want 0", rf_wdata); end
      total++; if (mdu_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_mdu_ready: got %0b want 1", mdu_ready); end
      total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall: got %0b want 0", stall); end
      total++; if (pipe_hold !== 1'b0) begin bad++; $display("[TB] FAIL reset_pipe_hold: got %0b want 0", pipe_hold); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_inputs();
      @(negedge clk);
      total++; if (rf_we !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_rf_we: got %0b want 0", rf_we); end
      next_cycle();
   endtask

   // Writeback to r3 shows on the port one cycle later; r0 is dropped.
   task automatic test_wb_write();
      wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'd100;
      @(negedge clk);
      total++; if (rf_we !== 1'b0) begin bad++; $display("[TB] FAIL wb_latency: got rf_we=%0b want 0", rf_we); end
      next_cycle();
      wb_addr = 5'd0; wb_data = 32'd55;
      @(negedge clk);
      total++; if (rf_we !== 1'b1) begin bad++; $display("[TB] FAIL wb_rf_we: got %0b want 1", rf_we); end
      total++; if (rf_waddr !== 5'd3) begin bad++; $display("[TB] FAIL wb_rf_waddr: got %0d want 3", rf_waddr); end
      total++; if (rf_wdata !== 32'd100) begin bad++; $display("[TB] FAIL wb_rf_wdata: got %0d want 100", rf_wdata); end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      total++; if (rf_we !== 1'b0) begin bad++; $display("[TB] FAIL wb_zero_dropped: got rf_we=%0b want 0", rf_we); end
      next_cycle();
   endtask

   // C0 issue r6; C1 read r6 + push result; C2 pop; C3 on port; C4 idle.
   task automatic test_mdu_path();
      issue_valid = 1'b1; issue_addr = 5'd6;
      @(negedge clk);
      total++; if (issue_ready !== 1'b1) begin bad++; $display("[TB] FAIL mdu_issue_ready: got %0b want 1", issue_ready); end
      next_cycle();
      issue_valid = 1'b0; rs_addr = 5'd6;
      mdu_valid = 1'b1; mdu_addr = 5'd6; mdu_data = 32'd100;
      @(negedge clk);
      total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL mdu_busy_stall: got %0b want 1", stall); end
      total++; if (mdu_ready !== 1'b1) begin bad++; $display("[TB] FAIL mdu_push_ready: got %0b want 1", mdu_ready); end
      next_cycle();
      mdu_valid = 1'b0;
      @(negedge clk);
      total++; if (rf_we !== 1'b0) begin bad++; $display("[TB] FAIL mdu_not_early: got rf_we=%0b want 0", rf_we); end
      total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL mdu_pop_stall: got %0b want 1", stall); end
      next_cycle();
      @(negedge clk);
      total++; if (rf_we !== 1'b1) begin bad++; $display("[TB] FAIL mdu_rf_we: got %0b want 1", rf_we); end
      total++; if (rf_waddr !== 5'd6) begin bad++; $display("[TB] FAIL mdu_rf_waddr: got %0d want 6", rf_waddr); end
      total++; if (rf_wdata !== 32'd100) begin bad++; $display("[TB] FAIL mdu_rf_wdata: got %0d want 100", rf_wdata); end
`ifdef REGFILE_BYPASS_EN
      total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL mdu_write_stall: got %0b want 0", stall); end
      total++; if (rdata_a !== 32'd100) begin bad++; $display("[TB] FAIL mdu_bypass_a: got %0h want 64", rdata_a); end
`else
      total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL mdu_write_stall: got %0b want 1", stall); end
      total++; if (rdata_a !== 32'h1111_1111) begin bad++; $display("[TB] FAIL mdu_passthru_a: got %0h want 11111111", rdata_a); end
`endif
      total++; if (rdata_b !== 32'h2222_2222) begin bad++; $display("[TB] FAIL mdu_rdata_b: got %0h want 22222222", rdata_b); end
      next_cycle();
      @(negedge clk);
      total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL mdu_after_stall: got %0b want 0", stall); end
      idle_inputs();
      next_cycle();
   endtask

   // S0 push r9 alongside wb; S1..S4 wb wins; S5 hold; S6 r9 on port.
   task automatic test_starvation();
      wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'd1;
      mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'h99;
      next_cycle();
      mdu_valid = 1'b0;
      for (int i = 2; i <= 5; i++) begin
         wb_addr = 5'(i); wb_data = 32'(i);
         @(negedge clk);
         total++; if (pipe_hold !== 1'b0) begin bad++; $display("[TB] FAIL starve_early_hold_%0d: got %0b want 0", i, pipe_hold); end
         next_cycle();
      end
      wb_valid = 1'b0;
      @(negedge clk);
      total++; if (pipe_hold !== 1'b1) begin bad++; $display("[TB] FAIL starve_hold: got %0b want 1", pipe_hold); end
      total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL starve_stall: got %0b want 1", stall); end
      next_cycle();
      wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 32'd2;
      @(negedge clk);
      total++; if (pipe_hold !== 1'b0) begin bad++; $display("[TB] FAIL starve_hold_once: got %0b want 0", pipe_hold); end
      total++; if (rf_waddr !== 5'd9 || rf_we !== 1'b1) begin bad++; $display("[TB] FAIL starve_head_write: got we=%0b addr=%0d want we=1 addr=9", rf_we, rf_waddr); end
      total++; if (rf_wdata !== 32'h99) begin bad++; $display("[TB] FAIL starve_head_data: got %0h want 99", rf_wdata); end
      idle_inputs();
      next_cycle();
      next_cycle();
   endtask

   // F0/F1 push r10,r11 under wb; F2 r12 refused; F3 pop on full, no push;
   // F4 push r12 + pop; F5..F6 drain; F7 empty.
   task automatic test_fifo_full();
      wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'd1;
      mdu_valid = 1'b1; mdu_addr = 5'd10; mdu_data = 32'hA0;
      @(negedge clk);
      total++; if (mdu_ready !== 1'b1) begin bad++; $display("[TB] FAIL full_ready0: got %0b want 1", mdu_ready); end
      next_cycle();
      wb_addr = 5'd2; mdu_addr = 5'd11; mdu_data = 32'hB0;
      @(negedge clk);
      total++; if (mdu_ready !== 1'b1) begin bad++; $display("[TB] FAIL full_ready1: got %0b want 1", mdu_ready); end
      next_cycle();
      wb_addr = 5'd3; mdu_addr = 5'd12; mdu_data = 32'hC0;
      @(negedge clk);
      total++; if (mdu_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_not_ready: got %0b want 0", mdu_ready); end
      next_cycle();
      wb_valid = 1'b0;
      @(negedge clk);
      total++; if (mdu_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_pop_no_push: got %0b want 0", mdu_ready); end
      next_cycle();
      @(negedge clk);
      total++; if (mdu_ready !== 1'b1) begin bad++; $display("[TB] FAIL full_ready_again: got %0b want 1", mdu_ready); end
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'hA0) begin bad++; $display("[TB] FAIL full_out0: got we=%0b addr=%0d data=%0h want 1/10/a0", rf_we, rf_waddr, rf_wdata); end
      next_cycle();
      mdu_valid = 1'b0;
      @(negedge clk);
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'hB0) begin bad++; $display("[TB] FAIL full_out1: got we=%0b addr=%0d data=%0h want 1/11/b0", rf_we, rf_waddr, rf_wdata); end
      next_cycle();
      @(negedge clk);
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hC0) begin bad++; $display("[TB] FAIL full_out2: got we=%0b addr=%0d data=%0h want 1/12/c0", rf_we, rf_waddr, rf_wdata); end
      next_cycle();
      @(negedge clk);
      total++; if (rf_we !== 1'b0) begin bad++; $display("[TB] FAIL full_drained: got rf_we=%0b want 0", rf_we); end
      idle_inputs();
      next_cycle();
   endtask

   // Re-issue to a busy register, set-beats-clear collision, and WAW.
   task automatic test_scoreboard();
      issue_valid = 1'b1; issue_addr = 5'd5;
      next_cycle();
      rs_addr = 5'd5;
      @(negedge clk);
      total++; if (issue_ready !== 1'b0) begin bad++; $display("[TB] FAIL sb_reissue_ready: got %0b want 0", issue_ready); end
      total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL sb_busy_stall: got %0b want 1", stall); end
      next_cycle();
      issue_valid = 1'b0;
      mdu_valid = 1'b1; mdu_addr = 5'd5; mdu_data = 32'h55;
      next_cycle();
      mdu_valid = 1'b0;
      next_cycle();
      rs_addr = 5'd0;
      @(negedge clk);
      total++; if (issue_ready !== 1'b1) begin bad++; $display("[TB] FAIL sb_cleared: got issue_ready=%0b want 1", issue_ready); end
      next_cycle();
      // Unissued result for r5; issue r5 in the cycle it pops.
      mdu_valid = 1'b1; mdu_addr = 5'd5; mdu_data = 32'h56;
      next_cycle();
      mdu_valid = 1'b0;
      issue_valid = 1'b1; issue_addr = 5'd5;
      @(negedge clk);
      total++; if (issue_ready !== 1'b1) begin bad++; $display("[TB] FAIL sb_collide_ready: got %0b want 1", issue_ready); end
      next_cycle();
      issue_valid = 1'b0;
      @(negedge clk);
      total++; if (issue_ready !== 1'b0) begin bad++; $display("[TB] FAIL sb_set_wins: got issue_ready=%0b want 0", issue_ready); end
      next_cycle();
      rs_addr = 5'd5;
      @(negedge clk);
      total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL sb_set_wins_stall: got %0b want 1", stall); end
      rs_addr = 5'd0;
      // WAW: writeback to a busy register writes but leaves it busy.
      issue_valid = 1'b1; issue_addr = 5'd7;
      next_cycle();
      issue_valid = 1'b0;
      wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
      next_cycle();
      wb_valid = 1'b0;
      @(negedge clk);
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h77) begin bad++; $display("[TB] FAIL sb_waw_write: got we=%0b addr=%0d data=%0h want 1/7/77", rf_we, rf_waddr, rf_wdata); end
      total++; if (issue_ready !== 1'b0) begin bad++; $display("[TB] FAIL sb_waw_busy: got issue_ready=%0b want 0", issue_ready); end
      next_cycle();
   endtask

   // Reset in mid-operation clears the scoreboard and the FIFO.
   task automatic test_mid_reset();
      mdu_valid = 1'b1; mdu_addr = 5'd8; mdu_data = 32'h88;
      wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'd1;
      next_cycle();
      idle_inputs();
      rst_n = 1'b0;
      issue_addr = 5'd7;
      @(negedge clk);
      total++; if (issue_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_busy: got issue_ready=%0b want 1", issue_ready); end
      total++; if (rf_we !== 1'b0) begin bad++; $display("[TB] FAIL midrst_rf_we: got %0b want 0", rf_we); end
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      @(negedge clk);
      total++; if (rf_we !== 1'b0) begin bad++; $display("[TB] FAIL midrst_fifo_lost: got rf_we=%0b want 0", rf_we); end
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_wb_write();
      test_mdu_path();
      test_starvation();
      test_fifo_full();
      test_scoreboard();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_write_sched.md
# regfile_write_sched

Write-port scheduler for the 32x32 register file. The register file has one write port (`regwrite`/`rd`/`writedata`); this block shares it between the pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). It buffers MDU results in a small FIFO and keeps a busy scoreboard of registers awaiting MDU results. It drives a decode-stage stall and, optionally, forwards the pending write to the read ports.

## Interface
Parameters:
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register address width
- `FIFO_DEPTH`, 2, MDU result buffer entries (power of 2, ≥2)
- `STARVE_MAX`, 4, consecutive writeback-won cycles before the FIFO is forced through

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wb_valid`  in  1  writeback stage writes this cycle
- `wb_addr`  in  ADDR_W  writeback destination
- `wb_data`  in  DATA_W  writeback data
- `mdu_valid`  in  1  MDU result offered
- `mdu_ready`  out  1  FIFO accepts the result
- `mdu_addr`  in  ADDR_W  MDU destination
- `mdu_data`  in  DATA_W  MDU result
- `issue_valid`  in  1  MDU op issued with a destination register
- `issue_addr`  in  ADDR_W  destination of the issued op
- `issue_ready`  out  1  `issue_addr` is not already busy
- `rs_addr`, `rt_addr`  in  ADDR_W  decode-stage read addresses
- `rf_rdata_a`, `rf_rdata_b`  in  DATA_W  register file read data (A, B)
- `rdata_a`, `rdata_b`  out  DATA_W  read data delivered to decode
- `stall`  out  1  decode must hold
- `pipe_hold`  out  1  writeback must not write this cycle
- `rf_we`, `rf_waddr`, `rf_wdata`  out  1/ADDR_W/DATA_W  register file write port

## Operation
- Writes to address 0 from either source are dropped: no port write is made. An MDU write to address 0 is still popped from the FIFO.
- Port arbitration, each cycle:
  - `wb_valid` with a non-zero address wins.
  - Otherwise, if the FIFO is non-empty, the FIFO head is written and popped.
- `mdu_ready = (count < FIFO_DEPTH)`.
  - Push happens on `mdu_valid && mdu_ready`.
  - When the FIFO is full, a pop in the same cycle does not enable a push.
- Starvation control: `starve_cnt` counts consecutive cycles in which the FIFO is non-empty and writeback wins.
  - When it reaches `STARVE_MAX`, `pipe_hold` asserts for exactly one cycle. The pipeline guarantees `wb_valid=0` in that cycle, so the FIFO head writes.
  - The counter clears on any FIFO write or when the FIFO is empty.
- Scoreboard `busy[31:1]`; `busy[0]` is constant 0.
  - Set on `issue_valid && issue_ready` for a non-zero `issue_addr`.
  - Cleared when that register's FIFO entry is written to the port.
  - If set and clear hit the same register in the same cycle, set wins.
  - A writeback to a busy register (WAW) is written but does not clear `busy`.
- `issue_ready = !busy[issue_addr]`.
- `stall = busy[rs_addr] | busy[rt_addr] | pipe_hold`, plus the pending-write term described under Configuration.

## Timing
- Port outputs are registered. A winning request in cycle N appears on `rf_we`/`rf_waddr`/`rf_wdata` in cycle N+1; the register file commits at the end of N+1.
- `mdu_ready`, `issue_ready` and `stall` are combinational from state and current inputs. `pipe_hold` is registered.
- A pushed MDU result can reach the port at the earliest 2 cycles after the push (push edge, then arbitration).
- Reset values:
  - `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `pipe_hold=0`.
  - FIFO empty, so `mdu_ready=1`.
  - `busy` all 0, `starve_cnt=0`, so `stall=0` unless the pending-write term applies.
- Reset mid-operation discards FIFO contents and the scoreboard. Queued MDU results are lost, and the MDU must be reset with the block.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - `rdata_a = rf_wdata` when `rf_we && rf_waddr==rs_addr && rs_addr!=0`; otherwise `rf_rdata_a`.
  - `rdata_b` works the same way against `rt_addr`.
  - No extra stall for the pending write.
- Not defined:
  - `rdata_a/b = rf_rdata_a/b`.
  - `stall` additionally asserts when `rf_we` is set and `rf_waddr` (non-zero) equals `rs_addr` or `rt_addr`.

## Structure
- Shared package `regfile_pkg`:
  - `DATA_W`/`ADDR_W` defaults
  - `reg_addr_t`, `reg_data_t`
  - FIFO entry struct `{addr, data}`
  - constant `REG_ZERO = 0`
- One sub-module, `regfile_wr_fifo`: synchronous FIFO with push/pop/count and `rst_n`. Arbitration, scoreboard and bypass stay in the top.

## Test plan
- Reset → all write-port outputs 0, `mdu_ready=1`, `stall=0`, `pipe_hold=0`; no write during reset.
- `wb_valid`, addr 3, data 100 → cycle+1: `rf_we=1`, `rf_waddr=3`, `rf_wdata=100`. Writeback to addr 0 → `rf_we` stays 0.
- Issue addr 6, then read `rs=6` → `stall=1`. MDU pushes addr 6, data 100 with no writeback → written 2 cycles after the push; `busy[6]` clears. With the macro: `rdata_a=100` and `stall=0` in the write cycle. Without it: `stall=1` for that extra cycle.
- Writeback valid to non-zero addresses every cycle with 1 FIFO entry pending → `pipe_hold=1` once after 4 writeback wins; FIFO head written the next cycle; counter resets.
- Push 2 MDU results while writeback is continuous → `mdu_ready=0` with a third `mdu_valid` held. A pop with push in the same full cycle → no push that cycle.
- `issue_valid` addr 5 while `busy[5]=1` → `issue_ready=0`, scoreboard unchanged. Issue addr 5 in the same cycle its entry is written → `busy[5]` remains 1.
